// File: rtl/banco_reg_wb.sv
// Architectural register bank with per-register pending bits, fed by the writeback mux.
// Two operand read ports see a same-cycle writeback through a bypass.
module banco_reg_wb_rd #(
    parameter int DATA_W = 3,
    parameter int ADDR_W = 3,
    parameter int NREG   = 8
) (
    input  logic [NREG-1:0][DATA_W-1:0] regs,
    input  logic [NREG-1:0]             busy,
    input  logic [ADDR_W-1:0]           ra,
    input  logic [ADDR_W-1:0]           wbE,
    input  logic [DATA_W-1:0]           wbD,
    input  logic                        wbWb,
    output logic [DATA_W-1:0]           rd,
    output logic                        bsy
);
    logic hit;

    // A writeback landing on the read address is forwarded and clears its pending state.
    assign hit = wbWb && (wbE == ra);
    assign rd  = hit ? wbD : regs[ra];
    assign bsy = busy[ra] & ~hit;
endmodule

module banco_reg_wb #(
    parameter int DATA_W = 3,
    parameter int ADDR_W = 3,
    parameter int NREG   = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] wbE,
    input  logic [DATA_W-1:0] wbD,
    input  logic              wbWb,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_dst,
    input  logic [ADDR_W-1:0] raA,
    input  logic [ADDR_W-1:0] raB,
    output logic [DATA_W-1:0] rdA,
    output logic [DATA_W-1:0] rdB,
    output logic              busyA,
    output logic              busyB,
    output logic [NREG-1:0]   busy_vec,
    output logic [ADDR_W:0]   busy_cnt,
    output logic              wb_stray
);
    localparam int NPORT = 2;

    logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NREG-1:0]             busy_q, busy_d;
    logic [ADDR_W:0]             cnt_q, cnt_d;
    logic                        stray_q, stray_d;

    logic [NPORT-1:0][ADDR_W-1:0] ra_p;
    logic [NPORT-1:0][DATA_W-1:0] rd_p;
    logic [NPORT-1:0]             bsy_p;

    always_comb begin
        regs_d  = regs_q;
        busy_d  = busy_q;
        stray_d = wbWb & ~busy_q[wbE];
        if (wbWb) begin
            regs_d[wbE] = wbD;
            busy_d[wbE] = 1'b0;
        end
        // Issue is applied last so a reservation beats a same-register writeback.
        if (issue_en) begin
            busy_d[issue_dst] = 1'b1;
        end
        cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + (ADDR_W+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs_q  <= '0;
            busy_q  <= '0;
            cnt_q   <= '0;
            stray_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            stray_q <= stray_d;
        end
    end

    assign ra_p = {raB, raA};

    for (genvar p = 0; p < NPORT; p++) begin : g_rd
        banco_reg_wb_rd #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W),
            .NREG  (NREG)
        ) u_rd (
            .regs(regs_q),
            .busy(busy_q),
            .ra  (ra_p[p]),
            .wbE (wbE),
            .wbD (wbD),
            .wbWb(wbWb),
            .rd  (rd_p[p]),
            .bsy (bsy_p[p])
        );
    end

    assign rdA      = rd_p[0];
    assign rdB      = rd_p[1];
    assign busyA    = bsy_p[0];
    assign busyB    = bsy_p[1];
    assign busy_vec = busy_q;
    assign busy_cnt = cnt_q;
    assign wb_stray = stray_q;
endmodule

// File: doc/banco_reg_wb.md
# banco_reg_wb

Architectural register bank with per-register pending (busy) bits, sitting directly downstream of the writeback mux. It has 8 registers of 3 bits each. Each cycle it accepts at most one writeback (address, data, valid), as selected by the mux. Issue logic reserves destination registers and reads two operands with same-cycle writeback bypass. It also reports stray writebacks and keeps a registered count of pending registers.

## Interface
Parameters
- DATA_W, 3, register data width (matches writeback data width)
- ADDR_W, 3, register address width
- NREG, 8, number of registers (2**ADDR_W)

Ports
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- wbE  input  ADDR_W  writeback destination register (mux outE)
- wbD  input  DATA_W  writeback data (mux outD)
- wbWb  input  1  writeback valid (mux outWb)
- issue_en  input  1  reserve a destination register this cycle
- issue_dst  input  ADDR_W  register to mark busy
- raA, raB  input  ADDR_W  operand read addresses
- rdA, rdB  output  DATA_W  operand values (combinational, bypassed)
- busyA, busyB  output  1  operand still pending (combinational, bypassed)
- busy_vec  output  NREG  registered busy bits, bit i = register i
- busy_cnt  output  ADDR_W+1  registered population count of busy_vec
- wb_stray  output  1  registered one-cycle pulse for a writeback to a non-busy register

## Operation
- Storage: regs[0..NREG-1] of DATA_W bits, plus busy[0..NREG-1].
- Writeback, wbWb=1 at a rising edge:
  - regs[wbE] <= wbD.
  - busy[wbE] <= 0, unless overridden by issue (see below).
  - If busy[wbE] was 0 before the edge, wb_stray <= 1 for one cycle. The data is still written.
- Issue, issue_en=1 at a rising edge: busy[issue_dst] <= 1. The value is unchanged unless a writeback also targets it.
- Simultaneous writeback and issue to the same register: the data is written and busy ends at 1 (issue wins). The stray check uses the pre-edge busy only.
- Simultaneous writeback and issue to different registers: both take effect independently.
- Reads, combinational:
  - rdA = (wbWb && wbE==raA) ? wbD : regs[raA].
  - busyA = busy[raA] & ~(wbWb && wbE==raA).
  - Port B is identical.
  - Issue in the same cycle does not affect reads, because operands are read before the destination is reserved.
- busy_cnt is the registered popcount of the next busy_vec, so it always equals popcount(busy_vec). Range 0..NREG with no wrap; NREG=8 needs 4 bits.
- Register 0 is an ordinary register: writable and reservable.

## Timing
- Reset (reset_n=0, asynchronous, takes effect immediately):
  - All regs = 0, busy_vec = 0, busy_cnt = 0, wb_stray = 0.
  - rdA/rdB = 0 and busyA/busyB = 0, unless bypassed by an active wbWb.
- Writes and busy updates are visible on the outputs one cycle after the edge; the bypass gives zero-latency visibility to the reads.
- wb_stray asserts for exactly one cycle, in the cycle after the offending edge.
- Reset asserted mid-operation discards every pending reservation; writebacks arriving later are flagged stray.
- There is no handshake and no backpressure: a writeback is always accepted in the cycle it is valid.

## Test plan
- Reset: hold reset_n=0, then release. Required: busy_vec=8'h00, busy_cnt=0, rdA=rdB=0 for all raA/raB.
- Reserve then write back:
  - Stimulus: issue_en=1, issue_dst=5 at edge 1; wbWb=1, wbE=5, wbD=3'b110 at edge 3.
  - After edge 1: busy_vec=8'h20, busy_cnt=1.
  - After edge 3: busy_vec=0, regs[5]=6, wb_stray=0.
- Bypass:
  - Stimulus: reg 2 busy; wbWb=1, wbE=2, wbD=7; raA=2, raB=2 in the same cycle.
  - Before the edge: rdA=rdB=7 and busyA=busyB=0.
  - After the edge: regs[2]=7.
- Same-register collision:
  - Stimulus: reg 4 busy; wbWb=1, wbE=4, wbD=1 and issue_en=1, issue_dst=4 at the same edge.
  - Required: regs[4]=1, busy[4]=1, busy_cnt unchanged, wb_stray=0.
- Stray writeback: with busy_vec=0, drive wbWb=1, wbE=3, wbD=2. Required: regs[3]=2 and wb_stray=1 for exactly one cycle.
- Fill and async reset:
  - Stimulus: issue regs 0..7 over 8 cycles, then pulse reset_n low between edges.
  - After the issues: busy_cnt=8 and busy_vec=8'hFF.
  - On reset: busy_vec=0 and busy_cnt=0 immediately, before the next clock edge.
